// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register owner with iterative multiply/divide for the execute stage
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   op_valid          EX holds a valid instruction this cycle
//   hilo_op[5:0]      {div, divu, mult, multu, mthi, mtlo}, one-hot
//   src_a, src_b      rs / rt operand values
//   cancel            flush; aborts any in-flight operation
//   stallreq          pipeline hold while an operation is outstanding
//   hilo_we[1:0]      {hi_we, lo_we} forwarding enables for this cycle
//   hi_wdata/lo_wdata values being written this cycle (zero when not writing)
//   hi_o/lo_o         architectural HI/LO registers
module hilo_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [5:0]      hilo_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  output logic            stallreq,
  output logic [1:0]      hilo_we,
  output logic [XLEN-1:0] hi_wdata,
  output logic [XLEN-1:0] lo_wdata,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;      // multiply: running product; divide: {remainder, quotient}
  logic [XLEN-1:0]   opa_q;      // multiplicand, or dividend shifted out MSB-first
  logic [XLEN-1:0]   opb_q;      // multiplier shifted out LSB-first, or divisor
  logic [XLEN-1:0]   hi_q, lo_q;
  logic              is_div_q;
  logic              neg_q_q;    // quotient/product sign
  logic              neg_r_q;    // remainder sign (dividend sign)
  logic              div0_fix_q; // signed divide by zero has its own fixed quotient

  // Exact-match decode: any pattern with more than one bit set matches nothing.
  logic op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo;
  assign op_div   = (hilo_op == 6'b100000);
  assign op_divu  = (hilo_op == 6'b010000);
  assign op_mult  = (hilo_op == 6'b001000);
  assign op_multu = (hilo_op == 6'b000100);
  assign op_mthi  = (hilo_op == 6'b000010);
  assign op_mtlo  = (hilo_op == 6'b000001);

  logic idle_go, accept, mt_write, signed_op;
  assign idle_go   = (state_q == S_IDLE) && op_valid && !cancel;
  assign accept    = idle_go && (op_div || op_divu || op_mult || op_multu);
  assign mt_write  = idle_go && (op_mthi || op_mtlo);
  assign signed_op = op_div || op_mult;

  logic [XLEN-1:0] a_mag, b_mag;
  assign a_mag = (signed_op && src_a[XLEN-1]) ? -src_a : src_a;
  assign b_mag = (signed_op && src_b[XLEN-1]) ? -src_b : src_b;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole product right by one.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: bring in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor, so XLEN+1 bits hold the shifted value.
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff, rem_nx;
  logic              fits;
  logic [2*XLEN-1:0] div_next;
  assign rem_sh   = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
  assign fits     = (rem_sh >= {1'b0, opb_q});
  assign rem_diff = rem_sh[XLEN-1:0] - opb_q;
  assign rem_nx   = fits ? rem_diff : rem_sh[XLEN-1:0];
  assign div_next = {rem_nx, acc_q[XLEN-2:0], fits};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q_q ? -acc_q : acc_q;
  assign rem_fix  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  always_comb begin
    quo_fix = neg_q_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    if (div0_fix_q) quo_fix = neg_r_q ? '1 : XLEN'(1);
  end

  always_comb begin
    stallreq = 1'b0;
    hilo_we  = 2'b00;
    hi_wdata = '0;
    lo_wdata = '0;
    if (!rst) begin
      if (accept || state_q == S_BUSY) stallreq = 1'b1;
      if (mt_write) begin
        if (op_mthi) begin
          hilo_we  = 2'b10;
          hi_wdata = src_a;
        end else begin
          hilo_we  = 2'b01;
          lo_wdata = src_a;
        end
      end else if (state_q == S_DONE && !cancel) begin
        hilo_we = 2'b11;
        if (is_div_q) begin
          hi_wdata = rem_fix;
          lo_wdata = quo_fix;
        end else begin
          {hi_wdata, lo_wdata} = prod_fix;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div0_fix_q <= 1'b0;
    end else begin
      if (hilo_we[1]) hi_q <= hi_wdata;
      if (hilo_we[0]) lo_q <= lo_wdata;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            opa_q      <= a_mag;
            opb_q      <= b_mag;
            acc_q      <= '0;
            cnt_q      <= '0;
            is_div_q   <= op_div || op_divu;
            neg_q_q    <= signed_op && (src_a[XLEN-1] ^ src_b[XLEN-1]);
            neg_r_q    <= signed_op && src_a[XLEN-1];
            div0_fix_q <= op_div && (src_b == '0);
            state_q    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cancel) begin
            state_q <= S_IDLE;
          end else begin
            if (is_div_q) begin
              acc_q <= div_next;
              opa_q <= opa_q << 1;
            end else begin
              acc_q <= mul_next;
              opb_q <= opb_q >> 1;
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - self-checking bench for hilo_unit
module tb_hilo_unit;

  localparam logic [5:0] OP_DIV   = 6'b100000;
  localparam logic [5:0] OP_DIVU  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [5:0]  hilo_op;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        stallreq;
  logic [1:0]  hilo_we;
  logic [31:0] hi_wdata, lo_wdata, hi_o, lo_o;

  int total = 0;
  int bad = 0;

  hilo_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .hilo_op(hilo_op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .stallreq(stallreq), .hilo_we(hilo_we), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Reference: architectural results from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OP_MULT:  begin q = sa * sb; return q; end
      OP_MULTU: return ua * ub;
      OP_DIVU:  begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      OP_DIV:   begin
        if (b == 32'h0) return {a, (a[31] ? 32'hFFFFFFFF : 32'h00000001)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default:  return 64'h0;
    endcase
  endfunction

  task automatic idle_inputs();
    op_valid = 1'b0; hilo_op = 6'h0; src_a = 32'h0; src_b = 32'h0; cancel = 1'b0;
  endtask

  // Presents op and holds it (as a stalled EX would) until the DONE cycle.
  task automatic do_muldiv(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hw, output logic [31:0] lw,
                           output int stalls, output int done_at, output int nwrites);
    hw = '0; lw = '0; stalls = 0; done_at = -1; nwrites = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; hilo_op = op; src_a = a; src_b = b; cancel = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (stallreq) stalls++;
      if (hilo_we != 2'b00) nwrites++;
      if (hilo_we == 2'b11) begin
        hw = hi_wdata; lw = lo_wdata; done_at = c;
        break;
      end
      @(posedge clk); #1;
      src_a = $urandom; src_b = $urandom;
    end
  endtask

  task automatic check_muldiv(input string name, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                              input bit release_after);
    logic [31:0] hw, lw;
    int stalls, done_at, nwrites;
    do_muldiv(op, a, b, hw, lw, stalls, done_at, nwrites);
    chk({name, ".done_at"}, 64'(done_at), 64'd33);
    chk({name, ".hi_wdata"}, hw, ehi);
    chk({name, ".lo_wdata"}, lw, elo);
    chk({name, ".stalls"}, 64'(stalls), 64'd33);
    chk({name, ".writes"}, 64'(nwrites), 64'd1);
    if (release_after) begin
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      chk({name, ".hi_o"}, hi_o, ehi);
      chk({name, ".lo_o"}, lo_o, elo);
      chk({name, ".stall_after"}, stallreq, 1'b0);
      chk({name, ".we_after"}, hilo_we, 2'b00);
    end
  endtask

  task automatic do_mt(input string name, input logic [5:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    op_valid = 1'b1; hilo_op = op; src_a = a; src_b = $urandom; cancel = 1'b0;
    @(negedge clk);
    chk({name, ".we"}, hilo_we, (op == OP_MTHI) ? 2'b10 : 2'b01);
    chk({name, ".hi_wdata"}, hi_wdata, (op == OP_MTHI) ? a : 32'h0);
    chk({name, ".lo_wdata"}, lo_wdata, (op == OP_MTLO) ? a : 32'h0);
    chk({name, ".stall"}, stallreq, 1'b0);
  endtask

  // Starts an op, then asserts cancel or rst in BUSY cycle 10.
  task automatic abort_run(input string name, input bit use_rst, input logic [31:0] ehi, input logic [31:0] elo);
    int writes11;
    writes11 = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; hilo_op = OP_MULT; src_a = 32'h00001234; src_b = 32'h00005678; cancel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (hilo_we == 2'b11) writes11++;
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1; else cancel = 1'b1;
    @(negedge clk);
    chk({name, ".we_abort"}, hilo_we, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    chk({name, ".stall_next"}, stallreq, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (hilo_we != 2'b00) writes11++;
      @(negedge clk);
    end
    chk({name, ".no_write"}, 64'(writes11), 64'd0);
    chk({name, ".hi_o"}, hi_o, ehi);
    chk({name, ".lo_o"}, lo_o, elo);
  endtask

  initial begin
    logic [31:0] mhi, mlo, ra, rb, hw, lw;
    logic [63:0] exp64;
    logic [5:0]  ops [6];
    logic [5:0]  rop;
    int          stalls, done_at, nwrites, sel;

    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_MULT;
    ops[3] = OP_MULTU; ops[4] = OP_MTHI; ops[5] = OP_MTLO;

    tbl.push_back('{"multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    tbl.push_back('{"div_m7_2",  OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    tbl.push_back('{"mult_m3_5", OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
    tbl.push_back('{"divu_by0",  OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF});
    tbl.push_back('{"div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    tbl.push_back('{"div_neg0",  OP_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF});
    tbl.push_back('{"div_pos0",  OP_DIV,   32'h00000009, 32'h00000000, 32'h00000009, 32'h00000001});
    tbl.push_back('{"divu_100_7",OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E});

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.stall", stallreq, 1'b0);
    chk("reset.we", hilo_we, 2'b00);
    chk("reset.hi_wdata", hi_wdata, 32'h0);
    chk("reset.lo_wdata", lo_wdata, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("reset.hi_o", hi_o, 32'h0);
    chk("reset.lo_o", lo_o, 32'h0);

    foreach (tbl[i]) check_muldiv(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo, 1'b1);

    // mthi then mtlo on consecutive cycles
    do_mt("mthi", OP_MTHI, 32'h12345678);
    do_mt("mtlo", OP_MTLO, 32'h9ABCDEF0);
    chk("mtlo.hi_o", hi_o, 32'h12345678);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("mt.lo_o", lo_o, 32'h9ABCDEF0);
    chk("mt.we_idle", hilo_we, 2'b00);

    // multi-bit op and cancel in IDLE are no-ops
    @(posedge clk); #1;
    op_valid = 1'b1; hilo_op = 6'b001010; src_a = 32'hDEADBEEF; src_b = 32'h3;
    @(negedge clk);
    chk("multibit.we", hilo_we, 2'b00);
    chk("multibit.stall", stallreq, 1'b0);
    @(posedge clk); #1;
    hilo_op = OP_MTHI; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_idle.we", hilo_we, 2'b00);
    @(posedge clk); #1;
    hilo_op = OP_MULT;
    @(negedge clk);
    chk("cancel_idle.stall", stallreq, 1'b0);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk);
    chk("noop.hi_o", hi_o, 32'h12345678);
    chk("noop.lo_o", lo_o, 32'h9ABCDEF0);
    chk("noop.stall", stallreq, 1'b0);

    // Back-to-back: op held through DONE, next op accepted the cycle after.
    check_muldiv("b2b_first", OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);
    check_muldiv("b2b_second", OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b1);

    abort_run("cancel", 1'b0, 32'h00000000, 32'h0000000C);
    abort_run("rst", 1'b1, 32'h00000000, 32'h00000000);

    // Randomized ops against the arithmetic model
    mhi = 32'h0; mlo = 32'h0;
    for (int n = 0; n < 30; n++) begin
      rop = ops[$urandom_range(0, 5)];
      sel = $urandom_range(0, 5);
      ra = $urandom;
      rb = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 2) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if (rop == OP_MTHI || rop == OP_MTLO) begin
        do_mt("rnd_mt", rop, ra);
        if (rop == OP_MTHI) mhi = ra; else mlo = ra;
      end else begin
        exp64 = ref_hilo(rop, ra, rb);
        do_muldiv(rop, ra, rb, hw, lw, stalls, done_at, nwrites);
        chk("rnd.result", {hw, lw}, exp64);
        chk("rnd.stalls", 64'(stalls), 64'd33);
        {mhi, mlo} = exp64;
      end
      @(posedge clk); #1; idle_inputs();
      @(negedge clk);
      chk("rnd.hilo", {hi_o, lo_o}, {mhi, mlo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
